// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM state codes, serve position and paddle-absent code.
package pong_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_POINT = 2'd2,
      ST_OVER  = 2'd3
   } state_e;

   localparam int unsigned CENTER_X    = 3;
   localparam int unsigned CENTER_Y    = 3;
   localparam logic [2:0]  PADDLE_NONE = 3'd7;

endpackage

// File: rtl/step_timer.sv
// Free-running step divider: tick is high for one clk every STEP_DIV clks.
module step_timer #(
   parameter int unsigned STEP_DIV = 25000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign tick = !clear && (r_cnt == LAST);

endmodule

// File: rtl/ball_controller.sv
// Pong ball controller: serves, moves and bounces the ball, detects paddle
// hits and misses, keeps score and ends the game at WIN_SCORE.
module ball_controller
   import pong_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned BIT_OF_WIDTH = 3,
   parameter int unsigned STEP_DIV     = 25000,
   parameter int unsigned HOLD_STEPS   = 4,
   parameter int unsigned WIN_SCORE    = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [2:0]              player_top,
   input  logic [2:0]              player_down,
   output logic [BIT_OF_WIDTH-1:0] x_pos,
   output logic [BIT_OF_WIDTH-1:0] y_pos,
   output logic [3:0]              score_top,
   output logic [3:0]              score_down,
   output logic [1:0]              game_state,
   output logic                    point_pulse
);

   localparam int unsigned BW = BIT_OF_WIDTH;
   localparam int unsigned HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
   localparam logic [BW-1:0] XY_ONE    = BW'(1);
   localparam logic [BW-1:0] X_MAX     = BW'(WIDTH - 1);
   localparam logic [BW-1:0] Y_TOP     = BW'(1);
   localparam logic [BW-1:0] Y_BOT     = BW'(WIDTH - 2);
   localparam logic [BW-1:0] Y_MAX     = BW'(WIDTH - 1);
   localparam logic [BW-1:0] X_CENTER  = BW'(CENTER_X);
   localparam logic [BW-1:0] Y_CENTER  = BW'(CENTER_Y);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
   localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

   state_e          r_state, w_state;
   logic [BW-1:0]   r_x, w_x, r_y, w_y, w_x_new;
   logic            r_dx, w_dx, r_dy, w_dy, w_dx_new;   // 1 = +1, 0 = -1
   logic [3:0]      r_score_top, w_score_top, r_score_down, w_score_down;
   logic            r_pulse, w_pulse;
   logic [HW-1:0]   r_hold, w_hold;
   logic            r_top_scored, w_top_scored;
   logic            w_tick, w_timer_clear;
   logic [3:0]      w_scorer_score;

   function automatic logic hit(input logic [2:0] p, input logic [BW-1:0] x);
      return (p != PADDLE_NONE) &&
             ((32'(x) == 32'(p)) || (32'(x) == 32'(p) + 32'd1));
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s >= WIN) ? s : s + 4'd1;
   endfunction

   assign w_timer_clear = (r_state == ST_IDLE) || (r_state == ST_OVER);

   step_timer #(.STEP_DIV(STEP_DIV)) u_step_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (w_timer_clear),
      .tick  (w_tick)
   );

   // Horizontal move with wall reflection; the hit test uses this new column.
   always_comb begin
      w_x_new  = r_x;
      w_dx_new = r_dx;
      if (r_dx && (r_x == X_MAX)) begin
         w_dx_new = 1'b0;
         w_x_new  = r_x - XY_ONE;
      end else if (!r_dx && (r_x == '0)) begin
         w_dx_new = 1'b1;
         w_x_new  = r_x + XY_ONE;
      end else begin
         w_x_new  = r_dx ? (r_x + XY_ONE) : (r_x - XY_ONE);
      end
   end

   assign w_scorer_score = r_top_scored ? r_score_top : r_score_down;

   always_comb begin
      w_state      = r_state;
      w_x          = r_x;
      w_y          = r_y;
      w_dx         = r_dx;
      w_dy         = r_dy;
      w_score_top  = r_score_top;
      w_score_down = r_score_down;
      w_pulse      = 1'b0;
      w_hold       = r_hold;
      w_top_scored = r_top_scored;
      case (r_state)
         ST_IDLE: begin
            w_x = X_CENTER;
            w_y = Y_CENTER;
            if (start) w_state = ST_PLAY;
         end
         ST_PLAY: begin
            if (w_tick) begin
               w_x  = w_x_new;
               w_dx = w_dx_new;
               if (!r_dy && (r_y == Y_TOP)) begin
                  if (hit(player_top, w_x_new)) begin
                     w_dy = 1'b1;
                  end else begin
                     w_y          = '0;
                     w_score_down = sat_inc(r_score_down);
                     w_pulse      = 1'b1;
                     w_top_scored = 1'b0;
                     w_hold       = '0;
                     w_state      = ST_POINT;
                  end
               end else if (r_dy && (r_y == Y_BOT)) begin
                  if (hit(player_down, w_x_new)) begin
                     w_dy = 1'b0;
                  end else begin
                     w_y          = Y_MAX;
                     w_score_top  = sat_inc(r_score_top);
                     w_pulse      = 1'b1;
                     w_top_scored = 1'b1;
                     w_hold       = '0;
                     w_state      = ST_POINT;
                  end
               end else begin
                  w_y = r_dy ? (r_y + XY_ONE) : (r_y - XY_ONE);
               end
            end
         end
         ST_POINT: begin
            // Re-serve toward the loser: a top point means bottom lost, so dy=+1.
            if (w_tick) begin
               if (r_hold == HOLD_LAST) begin
                  if (w_scorer_score == WIN) begin
                     w_state = ST_OVER;
                  end else begin
                     w_state = ST_IDLE;
                     w_x     = X_CENTER;
                     w_y     = Y_CENTER;
                     w_dy    = r_top_scored;
                  end
               end else begin
                  w_hold = r_hold + HW'(1);
               end
            end
         end
         ST_OVER: begin
            if (start) begin
               w_state      = ST_IDLE;
               w_x          = X_CENTER;
               w_y          = Y_CENTER;
               w_dx         = 1'b1;
               w_dy         = 1'b1;
               w_score_top  = '0;
               w_score_down = '0;
            end
         end
         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_x          <= X_CENTER;
         r_y          <= Y_CENTER;
         r_dx         <= 1'b1;
         r_dy         <= 1'b1;
         r_score_top  <= '0;
         r_score_down <= '0;
         r_pulse      <= 1'b0;
         r_hold       <= '0;
         r_top_scored <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_x          <= w_x;
         r_y          <= w_y;
         r_dx         <= w_dx;
         r_dy         <= w_dy;
         r_score_top  <= w_score_top;
         r_score_down <= w_score_down;
         r_pulse      <= w_pulse;
         r_hold       <= w_hold;
         r_top_scored <= w_top_scored;
      end
   end

   assign x_pos       = r_x;
   assign y_pos       = r_y;
   assign score_top   = r_score_top;
   assign score_down  = r_score_down;
   assign game_state  = r_state;
   assign point_pulse = r_pulse;

endmodule

// File: tb/tb_ball_controller.sv
// Vector bench for ball_controller: scripted rally with hand-derived ball
// positions, scores and states, checked through an expectation queue.
module tb_ball_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [2:0] player_top = 3'd7;
   logic [2:0] player_down = 3'd7;
   logic [2:0] x_pos, y_pos;
   logic [3:0] score_top, score_down;
   logic [1:0] game_state;
   logic       point_pulse;

   ball_controller #(
      .WIDTH(8), .BIT_OF_WIDTH(3), .STEP_DIV(4), .HOLD_STEPS(2), .WIN_SCORE(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .player_top(player_top), .player_down(player_down),
      .x_pos(x_pos), .y_pos(y_pos),
      .score_top(score_top), .score_down(score_down),
      .game_state(game_state), .point_pulse(point_pulse)
   );

   always #5 clk = ~clk;

   typedef enum int {K_RST, K_SERVE, K_TICK, K_START} kind_e;

   typedef struct {
      kind_e kind;
      int    pt, pd, st;
      int    x, y, s, sct, scd, pulse;
   } vec_t;

   vec_t vecs[$];
   vec_t sb_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   function automatic void add(input kind_e k, input int pt, input int pd, input int st,
                               input int x, input int y, input int s,
                               input int sct, input int scd, input int p);
      vec_t v;
      v.kind = k; v.pt = pt; v.pd = pd; v.st = st;
      v.x = x; v.y = y; v.s = s; v.sct = sct; v.scd = scd; v.pulse = p;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic tick(input int pt, input int pd, input int st,
                       input int x, input int y, input int s, input int sct, input int scd,
                       input int p);
      add(K_TICK, pt, pd, st, x, y, s, sct, scd, p);
   endtask

   initial begin
      vec_t v, e;
      int   px, py, ps;
      // Game 1: serve, bottom miss on the fourth step (start held in PLAY/POINT).
      add(K_RST,   7, 7, 1, 3, 3, 0, 0, 0, 0);
      add(K_SERVE, 7, 7, 1, 3, 3, 1, 0, 0, 0);
      tick(7, 7, 1, 4, 4, 1, 0, 0, 0);
      tick(7, 7, 1, 5, 5, 1, 0, 0, 0);
      tick(7, 7, 0, 6, 6, 1, 0, 0, 0);
      tick(7, 7, 0, 7, 7, 2, 1, 0, 1);
      tick(7, 7, 1, 7, 7, 2, 1, 0, 0);
      tick(7, 7, 1, 3, 3, 0, 1, 0, 0);
      // Long rally with wall and paddle bounces, then reset at (5,2).
      add(K_SERVE, 7, 7, 1, 3, 3, 1, 1, 0, 0);
      tick(7, 7, 0, 4, 4, 1, 1, 0, 0);
      tick(7, 7, 0, 5, 5, 1, 1, 0, 0);
      tick(7, 7, 0, 6, 6, 1, 1, 0, 0);
      tick(7, 6, 0, 7, 6, 1, 1, 0, 0);
      tick(7, 7, 0, 6, 5, 1, 1, 0, 0);
      tick(7, 7, 0, 5, 4, 1, 1, 0, 0);
      tick(7, 7, 0, 4, 3, 1, 1, 0, 0);
      tick(7, 7, 0, 3, 2, 1, 1, 0, 0);
      tick(7, 7, 0, 2, 1, 1, 1, 0, 0);
      tick(0, 7, 0, 1, 1, 1, 1, 0, 0);
      tick(7, 7, 0, 0, 2, 1, 1, 0, 0);
      tick(7, 7, 0, 1, 3, 1, 1, 0, 0);
      tick(7, 7, 0, 2, 4, 1, 1, 0, 0);
      tick(7, 7, 0, 3, 5, 1, 1, 0, 0);
      tick(7, 7, 0, 4, 6, 1, 1, 0, 0);
      tick(7, 4, 0, 5, 6, 1, 1, 0, 0);
      tick(7, 7, 0, 6, 5, 1, 1, 0, 0);
      tick(7, 7, 0, 7, 4, 1, 1, 0, 0);
      tick(7, 7, 0, 6, 3, 1, 1, 0, 0);
      tick(7, 7, 0, 5, 2, 1, 1, 0, 0);
      add(K_RST,   7, 7, 1, 3, 3, 0, 0, 0, 0);
      // Game 2: top miss, re-serve upward, bottom miss twice -> OVER.
      add(K_SERVE, 7, 7, 1, 3, 3, 1, 0, 0, 0);
      tick(7, 7, 0, 4, 4, 1, 0, 0, 0);
      tick(7, 7, 0, 5, 5, 1, 0, 0, 0);
      tick(7, 7, 0, 6, 6, 1, 0, 0, 0);
      tick(7, 6, 0, 7, 6, 1, 0, 0, 0);
      tick(7, 7, 0, 6, 5, 1, 0, 0, 0);
      tick(7, 7, 0, 5, 4, 1, 0, 0, 0);
      tick(7, 7, 0, 4, 3, 1, 0, 0, 0);
      tick(7, 7, 0, 3, 2, 1, 0, 0, 0);
      tick(7, 7, 0, 2, 1, 1, 0, 0, 0);
      tick(7, 7, 0, 1, 0, 2, 0, 1, 1);
      tick(7, 7, 0, 1, 0, 2, 0, 1, 0);
      tick(7, 7, 0, 3, 3, 0, 0, 1, 0);
      add(K_SERVE, 7, 7, 1, 3, 3, 1, 0, 1, 0);
      tick(7, 7, 0, 2, 2, 1, 0, 1, 0);
      tick(7, 7, 0, 1, 1, 1, 0, 1, 0);
      tick(0, 7, 0, 0, 1, 1, 0, 1, 0);
      tick(7, 7, 0, 1, 2, 1, 0, 1, 0);
      tick(7, 7, 0, 2, 3, 1, 0, 1, 0);
      tick(7, 7, 0, 3, 4, 1, 0, 1, 0);
      tick(7, 7, 0, 4, 5, 1, 0, 1, 0);
      tick(7, 7, 0, 5, 6, 1, 0, 1, 0);
      tick(7, 7, 0, 6, 7, 2, 1, 1, 1);
      tick(7, 7, 0, 6, 7, 2, 1, 1, 0);
      tick(7, 7, 0, 3, 3, 0, 1, 1, 0);
      add(K_SERVE, 7, 7, 1, 3, 3, 1, 1, 1, 0);
      tick(7, 7, 0, 4, 4, 1, 1, 1, 0);
      tick(7, 7, 0, 5, 5, 1, 1, 1, 0);
      tick(7, 7, 0, 6, 6, 1, 1, 1, 0);
      tick(7, 7, 0, 7, 7, 2, 2, 1, 1);
      tick(7, 7, 0, 7, 7, 2, 2, 1, 0);
      tick(7, 7, 0, 7, 7, 3, 2, 1, 0);
      tick(7, 7, 0, 7, 7, 3, 2, 1, 0);
      add(K_START, 7, 7, 1, 3, 3, 0, 0, 0, 0);
      add(K_SERVE, 7, 7, 1, 3, 3, 1, 0, 0, 0);
      tick(7, 7, 0, 4, 4, 1, 0, 0, 0);

      px = 3; py = 3; ps = 0;
      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         sb_q.push_back(v);
         player_top  = 3'(v.pt);
         player_down = 3'(v.pd);
         start       = (v.st != 0);
         rst         = (v.kind == K_RST);
         if (v.kind == K_TICK) begin
            // Between steps the ball must stay put and the pulse must be low.
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d.hold_x", i), 32'(x_pos), px);
            check($sformatf("v%0d.hold_y", i), 32'(y_pos), py);
            check($sformatf("v%0d.hold_state", i), 32'(game_state), ps);
            check($sformatf("v%0d.hold_pulse", i), 32'(point_pulse), 0);
         end
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         check($sformatf("v%0d.x", i), 32'(x_pos), e.x);
         check($sformatf("v%0d.y", i), 32'(y_pos), e.y);
         check($sformatf("v%0d.state", i), 32'(game_state), e.s);
         check($sformatf("v%0d.score_top", i), 32'(score_top), e.sct);
         check($sformatf("v%0d.score_down", i), 32'(score_down), e.scd);
         check($sformatf("v%0d.pulse", i), 32'(point_pulse), e.pulse);
         px = e.x; py = e.y; ps = e.s;
         @(negedge clk);
         rst   = 1'b0;
         start = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
